// File: rtl/tea_step_sequencer.sv
// Micro-step / round sequencer driving encrypt_logic.S for one TEA block encryption.
// Optional feature macro SEQ_SINGLE_STEP_EN adds a step_req input for debug single-stepping.
module tea_step_sequencer #(
  parameter int ROUNDS    = 32,
  parameter int LAST_STEP = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step_req,
`endif
  output logic [4:0] step,
  output logic [5:0] round,
  output logic       we,
  output logic       busy,
  output logic       done
);

  localparam logic [4:0] STEP_MAX  = 5'(LAST_STEP);
  localparam logic [5:0] ROUND_MAX = 6'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t     state, state_next;
  logic [4:0] step_next;
  logic [5:0] round_next;
  logic       busy_next;
  logic       done_next;
  logic       advance;

  // A micro-step is consumed only when RUN is not stalled; the write enable follows it.
`ifdef SEQ_SINGLE_STEP_EN
  assign advance = (state == RUN) && step_req && !hold;
`else
  assign advance = (state == RUN) && !hold;
`endif

  assign we = advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      round <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      step  <= step_next;
      round <= round_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    round_next = round;
    busy_next  = busy;
    done_next  = done;
    case (state)
      IDLE: begin
        done_next = 1'b0;
        if (start) begin
          state_next = RUN;
          step_next  = '0;
          round_next = '0;
          busy_next  = 1'b1;
        end
      end
      RUN: begin
        if (advance) begin
          if (step < STEP_MAX) begin
            step_next = step + 5'd1;
          end else if (round < ROUND_MAX) begin
            step_next  = '0;
            round_next = round + 6'd1;
          end else begin
            // Final step of final round: round stays visible during the done pulse.
            state_next = FIN;
            step_next  = '0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end
      end
      FIN: begin
        state_next = IDLE;
        done_next  = 1'b0;
        round_next = '0;
      end
      default: begin
        state_next = IDLE;
        step_next  = '0;
        round_next = '0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
      end
    endcase
  end

endmodule
